// File: rtl/load_store_unit.sv
// Load/store unit: accepts load/store requests from execute and drives a
// word-organised data memory. Loads are byte/halfword extracted and
// sign/zero extended; SB/SH are done as read-modify-write of the whole word.
// Ports:
//   clk, reset                      clock (rising edge), async active-high reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_write, req_funct3           store flag and RV32I width/sign code
//   req_addr, req_wdata             byte address, right-aligned store data
//   resp_valid, resp_rdata, resp_err  one-cycle response pulse, load data, error
//   mem_write, mem_read             memory strobes
//   mem_address, mem_wr_data        word address and full write word
//   mem_rd_data                     combinational memory read data
module load_store_unit #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_wr_data,
    input  logic [31:0]       mem_rd_data
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMWRD,
        WRITE,
        RESP
    } state_t;

    state_t      state;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [15:0] wdata_q;

    logic f3_bad;
    logic misaligned;
    logic out_of_range;
    logic req_err;

    always_comb begin
        if (req_write)
            f3_bad = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
        else
            f3_bad = !(req_funct3 inside {3'b000, 3'b001, 3'b010,
                                          3'b100, 3'b101});
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                  || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = |req_addr[31:ADDR_W+2];
        req_err = f3_bad | misaligned | out_of_range;
    end

    // Little-endian lane pick: byte lane = off, halfword lane = off[1].
    function automatic logic [31:0] extract(input logic [31:0] w,
                                            input logic [1:0]  off,
                                            input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b100:  extract = {24'd0, b};
            3'b101:  extract = {16'd0, h};
            default: extract = w;
        endcase
    endfunction

    // Only SB (f3=000) and SH (f3=001) reach the merge path.
    function automatic logic [31:0] merge(input logic [31:0] w,
                                          input logic [15:0] wd,
                                          input logic [1:0]  off,
                                          input logic [2:0]  f3);
        logic [31:0] m;
        m = w;
        if (f3[0])
            m[{off[1], 4'b0000} +: 16] = wd;
        else
            m[{off, 3'b000} +: 8] = wd[7:0];
        return m;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            off_q       <= '0;
            f3_q        <= '0;
            wdata_q     <= '0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            mem_write   <= 1'b0;
            mem_read    <= 1'b0;
            mem_address <= '0;
            mem_wr_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        off_q     <= req_addr[1:0];
                        f3_q      <= req_funct3;
                        wdata_q   <= req_wdata[15:0];
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            state      <= RESP;
                        end else if (!req_write) begin
                            mem_read    <= 1'b1;
                            mem_address <= req_addr[ADDR_W+1:2];
                            state       <= LOAD;
                        end else if (req_funct3 == 3'b010) begin
                            mem_write   <= 1'b1;
                            mem_wr_data <= req_wdata;
                            mem_address <= req_addr[ADDR_W+1:2];
                            state       <= WRITE;
                        end else begin
                            mem_read    <= 1'b1;
                            mem_address <= req_addr[ADDR_W+1:2];
                            state       <= RMWRD;
                        end
                    end
                end
                LOAD: begin
                    mem_read    <= 1'b0;
                    mem_address <= '0;
                    resp_rdata  <= extract(mem_rd_data, off_q, f3_q);
                    resp_valid  <= 1'b1;
                    state       <= RESP;
                end
                RMWRD: begin
                    // Address is kept for the write-back cycle.
                    mem_read    <= 1'b0;
                    mem_write   <= 1'b1;
                    mem_wr_data <= merge(mem_rd_data, wdata_q, off_q, f3_q);
                    state       <= WRITE;
                end
                WRITE: begin
                    mem_write   <= 1'b0;
                    mem_wr_data <= '0;
                    mem_address <= '0;
                    resp_valid  <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed steps plus randomized requests
// checked against a behavioural memory/response model.
module tb_load_store_unit;

    localparam int AW = 6;
    localparam int NW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          mem_write;
    logic          mem_read;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_wr_data;
    logic [31:0]   mem_rd_data;

    load_store_unit #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_address(mem_address), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [NW];
    logic [31:0] ref_mem [NW];
    bit mem_init = 1'b0;
    int unsigned cyc = 0;

    assign mem_rd_data = mem[mem_address];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < NW; i++) mem[i] <= ref_mem[i];
        end else if (mem_write) begin
            mem[mem_address] <= mem_wr_data;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_err(input bit wr, input logic [2:0] f3,
                                   input logic [31:0] a);
        int size;
        if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
        if (!wr && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        size = 1 << f3[1:0];
        if ((a % size) != 0) return 1'b1;
        if (a >= 4 * NW) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                             input logic [31:0] a);
        longint w, v, mask;
        int sh, size;
        w = longint'(ref_mem[int'(a / 4)]);
        sh = int'(a % 4) * 8;
        size = 1 << f3[1:0];
        mask = (64'd1 << (8 * size)) - 1;
        v = (w >> sh) & mask;
        if (!f3[2] && size < 4 && v >= (mask + 1) / 2) v = v - (mask + 1);
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_store(input logic [2:0] f3,
                                              input logic [31:0] a,
                                              input logic [31:0] wd);
        longint w, mask, oldv;
        int sh, size;
        w = longint'(ref_mem[int'(a / 4)]);
        sh = int'(a % 4) * 8;
        size = 1 << f3[1:0];
        mask = (64'd1 << (8 * size)) - 1;
        oldv = (w >> sh) & mask;
        w = w - (oldv << sh) + ((longint'(wd) & mask) << sh);
        return w[31:0];
    endfunction

    task automatic do_req(input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input string tag, output logic [31:0] rd);
        bit e, saw_rd, saw_wr, addr_ok, busy_ok;
        logic [31:0] exp_r, exp_w, wword;
        int exp_lat, lat;
        e = ref_err(wr, f3, a);
        exp_r = '0;
        exp_w = '0;
        wword = '0;
        if (!e && !wr) exp_r = ref_load(f3, a);
        if (!e && wr) exp_w = ref_store(f3, a, wd);
        exp_lat = (wr && f3 != 3'd2) ? 3 : 2;
        @(negedge clk);
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr = $urandom;
        req_wdata = $urandom;
        lat = 0;
        saw_rd = 0;
        saw_wr = 0;
        addr_ok = 1;
        busy_ok = 1;
        do begin
            @(negedge clk);
            lat++;
            if (req_ready) busy_ok = 0;
            if ((mem_read || mem_write) && mem_address !== AW'(a >> 2))
                addr_ok = 0;
            if (mem_read) saw_rd = 1;
            if (mem_write) begin
                saw_wr = 1;
                wword = mem_wr_data;
            end
        end while (!resp_valid && lat < 8);
        rd = resp_rdata;
        check({tag, ".resp_seen"}, 32'(resp_valid), 32'd1);
        check({tag, ".err"}, 32'(resp_err), 32'(e));
        check({tag, ".rdata"}, resp_rdata, exp_r);
        check({tag, ".busy"}, 32'(busy_ok), 32'd1);
        check({tag, ".mem_read"}, 32'(saw_rd), 32'(!e && (!wr || f3 != 3'd2)));
        check({tag, ".mem_write"}, 32'(saw_wr), 32'(!e && wr));
        check({tag, ".addr"}, 32'(addr_ok), 32'd1);
        if (!e) check({tag, ".latency"}, lat, exp_lat);
        if (!e && wr) begin
            check({tag, ".wr_word"}, wword, exp_w);
            ref_mem[int'(a / 4)] = exp_w;
        end
        @(negedge clk);
        check({tag, ".pulse"}, 32'(resp_valid), 32'd0);
        check({tag, ".rd_idle"}, resp_rdata, 32'd0);
        check({tag, ".ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] b2b_exp [3];
        logic [31:0] b2b_addr [3];
        logic [2:0]  b2b_f3 [3];
        int unsigned acc [3];
        int idx, nresp, extra;
        bit rr, saw_w, saw_low;

        reset = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_funct3 = '0;
        req_addr = '0;
        req_wdata = '0;
        for (int i = 0; i < NW; i++) ref_mem[i] = $urandom;
        mem_init = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.strobes", {28'd0, resp_valid, resp_err, mem_write, mem_read},
              32'd0);
        check("rst.addr", 32'(mem_address), 32'd0);
        check("rst.wdata", mem_wr_data, 32'd0);
        check("rst.rdata", resp_rdata, 32'd0);
        reset = 1'b0;

        do_req(1, 3'd2, 32'h08, 32'hDEADBEEF, "sw8", rd);
        do_req(0, 3'd2, 32'h08, 32'h0, "lw8", rd);
        check("lw8.const", rd, 32'hDEADBEEF);

        do_req(1, 3'd2, 32'h08, 32'h80817F01, "sw8b", rd);
        do_req(0, 3'd0, 32'h09, 32'h0, "lb9", rd);
        check("lb9.const", rd, 32'h0000007F);
        do_req(0, 3'd0, 32'h0B, 32'h0, "lbB", rd);
        check("lbB.const", rd, 32'hFFFFFF80);
        do_req(0, 3'd4, 32'h0B, 32'h0, "lbuB", rd);
        check("lbuB.const", rd, 32'h00000080);
        do_req(0, 3'd1, 32'h0A, 32'h0, "lhA", rd);
        check("lhA.const", rd, 32'hFFFF8081);
        do_req(0, 3'd5, 32'h0A, 32'h0, "lhuA", rd);
        check("lhuA.const", rd, 32'h00008081);

        do_req(1, 3'd2, 32'h0C, 32'h11223344, "sw12", rd);
        do_req(1, 3'd0, 32'h0D, 32'h000000AA, "sbD", rd);
        do_req(0, 3'd2, 32'h0C, 32'h0, "lwC1", rd);
        check("sbD.const", rd, 32'h1122AA44);
        do_req(1, 3'd1, 32'h0E, 32'h0000BEEF, "shE", rd);
        do_req(0, 3'd2, 32'h0C, 32'h0, "lwC2", rd);
        check("shE.const", rd, 32'hBEEFAA44);

        do_req(0, 3'd2, 32'h06, 32'h0, "err_lw6", rd);
        do_req(1, 3'd1, 32'h03, 32'h1234, "err_sh3", rd);
        do_req(0, 3'd2, 32'h100, 32'h0, "err_lw100", rd);
        do_req(0, 3'd3, 32'h10, 32'h0, "err_f3", rd);
        do_req(1, 3'd4, 32'h10, 32'h55, "err_sf3", rd);

        // Reset during the WRITE cycle of an SB.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_funct3 = 3'd0;
        req_addr = 32'h11;
        req_wdata = 32'h000000C3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        saw_w = 0;
        for (int i = 0; i < 5 && !saw_w; i++) begin
            @(negedge clk);
            if (mem_write) saw_w = 1;
        end
        check("rstmid.write_seen", 32'(saw_w), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rstmid.write_drop", 32'(mem_write), 32'd0);
        check("rstmid.no_resp", 32'(resp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) extra++;
        end
        check("rstmid.resp_count", extra, 0);
        check("rstmid.ready", 32'(req_ready), 32'd1);
        do_req(0, 3'd2, 32'h10, 32'h0, "rstmid.lw", rd);

        // Back-to-back loads with req_valid held high.
        b2b_addr[0] = 32'h08; b2b_f3[0] = 3'd2;
        b2b_addr[1] = 32'h0C; b2b_f3[1] = 3'd2;
        b2b_addr[2] = 32'h0B; b2b_f3[2] = 3'd4;
        for (int i = 0; i < 3; i++) begin
            b2b_exp[i] = ref_load(b2b_f3[i], b2b_addr[i]);
            acc[i] = 0;
        end
        idx = 0;
        nresp = 0;
        saw_low = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_funct3 = b2b_f3[0];
        req_addr = b2b_addr[0];
        for (int c = 0; c < 30 && nresp < 3; c++) begin
            rr = req_ready;
            if (!rr) saw_low = 1;
            if (resp_valid) begin
                check("b2b.rdata", resp_rdata, b2b_exp[nresp]);
                nresp++;
            end
            @(posedge clk);
            #1;
            if (rr && idx < 3) begin
                acc[idx] = cyc;
                idx++;
            end
            if (idx < 3) begin
                req_funct3 = b2b_f3[idx];
                req_addr = b2b_addr[idx];
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid) extra++;
        end
        check("b2b.resp_count", nresp, 3);
        check("b2b.accept_count", idx, 3);
        check("b2b.no_dup", extra, 0);
        check("b2b.ready_low", 32'(saw_low), 32'd1);
        check("b2b.gap01", acc[1] - acc[0], 3);
        check("b2b.gap12", acc[2] - acc[1], 3);

        for (int n = 0; n < 300; n++) begin
            bit wr;
            logic [2:0] f3;
            logic [31:0] a;
            wr = 1'($urandom_range(0, 1));
            f3 = 3'($urandom);
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            do_req(wr, f3, a, $urandom, "rnd", rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
